instruction_fetch_stage: RTL and testbench

- IF stage of the five-stage MIPS pipeline. Holds the PC and fetches from an external instruction memory through a ready/valid handshake.
- Registers the fetched word plus PC+4 into the IF/ID pipeline register that feeds the instruction decoder.
- Accepts stall from the hazard unit and redirect (branch/jump) from the decode stage; a redirect flushes the fetched slot.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/ifid_pipeline_reg.sv | 57 +++++
 rtl/instruction_fetch_stage.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM states, instruction
// width, the NOP encoding, opcodes shared with the decoder, and a saturating
// counter helper.
package mips_pkg;

    localparam int          INSTR_W    = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;   // sll $0,$0,0

    localparam logic [5:0]  OP_J       = 6'b000010;
    localparam logic [5:0]  OP_BEQ     = 6'b000100;
    localparam logic [5:0]  OP_BNE     = 6'b000101;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ifid_pipeline_reg.sv
// Generic stage register holding an instruction, its PC+4 and a valid bit.
// flush loads a bubble (NOP, valid=0, PC+4 kept); load captures the inputs;
// otherwise the contents hold. flush wins over load.
module ifid_pipeline_reg
    import mips_pkg::*;
#(
    parameter int                 PC_WIDTH = 32,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                flush,
    input  logic [INSTR_W-1:0]  in_instruction,
    input  logic [PC_WIDTH-1:0] in_pc_plus_4,
    output logic [INSTR_W-1:0]  instruction,
    output logic [PC_WIDTH-1:0] pc_plus_4,
    output logic                valid
);

    logic [INSTR_W-1:0]  instr_d, instr_q;
    logic [PC_WIDTH-1:0] pc4_d,   pc4_q;
    logic                valid_d, valid_q;

    // Next contents: bubble on flush, capture on load, otherwise hold
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = in_instruction;
            pc4_d   = in_pc_plus_4;
            valid_d = 1'b1;
        end
    end

    // Register update with synchronous active-low reset to an empty slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instruction = instr_q;
    assign pc_plus_4   = pc4_q;
    assign valid       = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, fetches over a ready/valid instruction-memory port
// and fills the IF/ID register. Priority: reset > redirect > stall > fetch.
// Optional macro IF_PERF_COUNTERS_EN adds perf_fetched / perf_bubbles.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [INSTR_W-1:0]  NOP_WORD = NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_addr,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_addr,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  ifid_instruction,
    output logic [PC_WIDTH-1:0] ifid_pc_plus_4,
    output logic                ifid_valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubbles
`endif
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    fetch_state_e        state_d, state_q;
    logic [PC_WIDTH-1:0] pc_d, pc_q;
    logic [PC_WIDTH-1:0] pc_plus_4;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                redirect;
    logic                accept;
    logic                ifid_load;
    logic                ifid_flush;

    assign pc_plus_4       = pc_q + PC_WIDTH'(4);
    assign redirect        = jump | branch_taken;
    // Jump wins over a simultaneous taken branch; targets are word-aligned
    assign redirect_target = (jump ? jump_addr : branch_addr) & ALIGN_MASK;
    assign imem_addr       = pc_q;

    // Next PC, fetch FSM transition and IF/ID control
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        accept     = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (redirect) begin
            // Squashes whatever is pending, even under stall
            pc_d       = redirect_target;
            state_d    = FETCH;
            ifid_flush = 1'b1;
        end else if (!stall) begin
            case (state_q)
                FETCH, WAIT: begin
                    if (imem_ready) begin
                        accept    = 1'b1;
                        ifid_load = 1'b1;
                        pc_d      = pc_plus_4;
                        state_d   = FETCH;
                    end else begin
                        ifid_flush = 1'b1;
                        state_d    = WAIT;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Request is asserted in both fetch states, and dropped while in reset
    always_comb begin
        imem_req = 1'b0;
        case (state_q)
            FETCH:   imem_req = rst_n;
            WAIT:    imem_req = rst_n;
            default: imem_req = 1'b0;
        endcase
    end

    // PC and FSM state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC & ALIGN_MASK;
            state_q <= FETCH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    ifid_pipeline_reg #(
        .PC_WIDTH (PC_WIDTH),
        .NOP_WORD (NOP_WORD)
    ) u_ifid (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (ifid_load),
        .flush          (ifid_flush),
        .in_instruction (imem_rdata),
        .in_pc_plus_4   (pc_plus_4),
        .instruction    (ifid_instruction),
        .pc_plus_4      (ifid_pc_plus_4),
        .valid          (ifid_valid)
    );

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetched_d, fetched_q;
    logic [31:0] bubbles_d, bubbles_q;

    // Saturating counts of accepted words and of bubbles loaded into IF/ID
    always_comb begin
        fetched_d = accept     ? sat_inc32(fetched_q) : fetched_q;
        bubbles_d = ifid_flush ? sat_inc32(bubbles_q) : bubbles_q;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    // accept only feeds the optional counters
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a reference model pushes the
// expected IF/ID contents and next PC for every driven cycle; they are popped
// and compared one cycle later. Define IF_PERF_COUNTERS_EN to cover counters.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        jump;
    logic [31:0] jump_addr;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus_4;
    logic        ifid_valid;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_addr      (branch_addr),
        .jump             (jump),
        .jump_addr        (jump_addr),
        .imem_addr        (imem_addr),
        .imem_req         (imem_req),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .ifid_instruction (ifid_instruction),
        .ifid_pc_plus_4   (ifid_pc_plus_4),
        .ifid_valid       (ifid_valid)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_bubbles     (perf_bubbles)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;
    logic [31:0] m_fetched, m_bubbles;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0;
        m_fetched = 32'h0; m_bubbles = 32'h0;
    endtask

    // Reset cycle; other inputs may be active to show reset dominates
    task automatic do_reset(input logic rdy, input logic st, input logic jp);
        @(negedge clk);
        rst_n = 1'b0; stall = st; jump = jp; jump_addr = 32'h0000_0200;
        branch_taken = 1'b0; branch_addr = 32'h0; imem_ready = rdy;
        imem_rdata = 32'hDEAD_BEEF;
        #1 chk("req_in_reset", {31'b0, imem_req}, 32'h0);
        @(posedge clk); #1;
        model_reset();
        chk("rst_pc",    imem_addr,        m_pc);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_instr", ifid_instruction, NOP);
        chk("rst_pp4",   ifid_pc_plus_4,   32'h0);
    endtask

    // One driven cycle: drive at negedge, predict, compare after the edge
    task automatic step(input logic st, input logic br, input logic [31:0] ba,
                        input logic jp, input logic [31:0] ja,
                        input logic rdy, input logic [31:0] rd);
        exp_t e;
        logic [31:0] tgt;
        @(negedge clk);
        rst_n = 1'b1; stall = st; branch_taken = br; branch_addr = ba;
        jump = jp; jump_addr = ja; imem_ready = rdy; imem_rdata = rd;
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_req",  {31'b0, imem_req}, 32'h1);
        if (jp || br) begin
            tgt = (jp ? ja : ba) & ~32'h3;
            m_pc = tgt; m_instr = NOP; m_valid = 1'b0;
            m_bubbles = m_bubbles + 1;
        end else if (!st) begin
            if (rdy) begin
                m_instr = rd; m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_fetched = m_fetched + 1;
            end else begin
                m_instr = NOP; m_valid = 1'b0;
                m_bubbles = m_bubbles + 1;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("next_pc",    imem_addr,        e.pc);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
        chk("ifid_instr", ifid_instruction, e.instr);
        chk("ifid_pp4",   ifid_pc_plus_4,   e.pp4);
    endtask

    task automatic fetch(input logic rdy);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy, $urandom);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        jump = 1'b0; jump_addr = '0; imem_ready = 1'b0; imem_rdata = '0;
        model_reset();

        do_reset(1'b1, 1'b0, 1'b0);

        // Zero-wait streaming with a fixed word
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_C020);
        // pc is 12; back up to 8 for the wait scenario via a jump
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, $urandom);
        // Three not-ready cycles at 8, then accept, then one more
        for (int i = 0; i < 3; i++) fetch(1'b0);
        fetch(1'b1);
        fetch(1'b1);
        // Stall at pc=16 with imem_ready high (ignored), then resume
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0001);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0002);
        fetch(1'b1);
        // Branch at pc=20, then fetch at the target
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, $urandom);
        fetch(1'b1);
        // Jump and branch together: jump wins
        step(1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0, $urandom);
        fetch(1'b1);
        // Misaligned target gets its low bits cleared
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0107, 1'b1, $urandom);
        // Redirect beats stall, including out of a wait
        fetch(1'b0);
        step(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, $urandom);
        fetch(1'b1);
        // Stall while waiting, then ready
        fetch(1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, $urandom);
        fetch(1'b1);
        // PC wrap at the top of the address space
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, $urandom);
        fetch(1'b1);
        fetch(1'b1);
        // Reset during a wait at address 24 (ready and jump also high)
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'd24, 1'b1, $urandom);
        fetch(1'b0);
        do_reset(1'b1, 1'b1, 1'b1);
        fetch(1'b1);

        // Counter scenario: 5 accepts, 2 waits, 1 redirect
        do_reset(1'b0, 1'b0, 1'b0);
        fetch(1'b1); fetch(1'b1);
        fetch(1'b0); fetch(1'b0);
        fetch(1'b1);
        step(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, $urandom);
        fetch(1'b1); fetch(1'b1);
`ifdef IF_PERF_COUNTERS_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_bubbles", perf_bubbles, m_bubbles);
        chk("perf_fetched_5", perf_fetched, 32'd5);
        chk("perf_bubbles_3", perf_bubbles, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end, expected completion");
        $fatal(1, "timeout");
    end

endmodule
